// File: rtl/pipe_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_stage_pkg
// Shared constants and types for the stage-3 hit collection path.
//   PARALLEL_SIZE : lanes per input beat
//   PARA          : candidate index width
//   hit_entry_t   : one FIFO entry {idx, last, null_f}
//   sat16         : clamp a 17-bit sum to 16 bits
// -----------------------------------------------------------------------------
package pipe_stage_pkg;

  localparam int PARALLEL_SIZE = 12;
  localparam int PARA          = 16;

  typedef struct packed {
    logic [PARA-1:0] idx;
    logic            last;
    logic            null_f;
  } hit_entry_t;

  function automatic logic [15:0] sat16(input logic [16:0] v);
    return v[16] ? 16'hFFFF : v[15:0];
  endfunction

endpackage : pipe_stage_pkg

// File: rtl/stage3_hit_compactor.sv
// -----------------------------------------------------------------------------
// stage3_hit_compactor
// Purely combinational lane compaction helper.
//   in_flag  : per-lane hit flags
//   lane_off : exclusive prefix popcount per lane (write offset of that lane)
//   hit_cnt  : total number of flagged lanes (k)
//   hi_lane  : highest flagged lane (0 when no lane is flagged)
// -----------------------------------------------------------------------------
module stage3_hit_compactor #(
  parameter int PARALLEL_SIZE = pipe_stage_pkg::PARALLEL_SIZE,
  parameter int OFF_W         = $clog2(PARALLEL_SIZE + 1),
  parameter int LANE_W        = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1
) (
  input  logic [PARALLEL_SIZE-1:0]            in_flag,
  output logic [PARALLEL_SIZE-1:0][OFF_W-1:0] lane_off,
  output logic [OFF_W-1:0]                    hit_cnt,
  output logic [LANE_W-1:0]                   hi_lane
);

  logic [OFF_W-1:0] run;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    run      = '0;
    hi_lane  = '0;
    lane_off = '0;
    for (int i = 0; i < PARALLEL_SIZE; i++) begin
      // NOTE: blocking assignments are required here: 'run' is a running sum
      // that each lane must see updated by the lanes below it.
      lane_off[i] = run;
      if (in_flag[i]) begin
        run     = run + OFF_W'(1);
        hi_lane = LANE_W'(i);
      end
    end
    hit_cnt = run;
  end

endmodule : stage3_hit_compactor

// File: rtl/stage3_hit_collector.sv
// -----------------------------------------------------------------------------
// stage3_hit_collector
// Compacts flagged lane indices of each accepted beat into a FIFO (ascending
// lane order) and streams them out one per cycle. Marks frame ends with a
// last tag (or a terminator entry when the final beat has no hits) and reports
// the per-frame hit count.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_flag, in_idx      : per-lane flag and index
//   in_last              : beat closes the current frame
//   out_valid/out_ready  : output handshake (first-word-fall-through)
//   out_idx/out_last     : head index and frame-end tag
//   out_null             : head is the terminator of a frame with no hits
//   frame_hits           : saturating hit count of the last completed frame
//   frame_done           : one-cycle pulse when frame_hits updates
// -----------------------------------------------------------------------------
module stage3_hit_collector #(
  parameter int PARALLEL_SIZE = pipe_stage_pkg::PARALLEL_SIZE,
  parameter int PARA          = pipe_stage_pkg::PARA,
  parameter int DEPTH         = 32
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [PARALLEL_SIZE-1:0]            in_flag,
  input  logic [PARALLEL_SIZE-1:0][PARA-1:0]  in_idx,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [PARA-1:0]                     out_idx,
  output logic                                out_last,
  output logic                                out_null,
  output logic [15:0]                         frame_hits,
  output logic                                frame_done
);

  import pipe_stage_pkg::*;

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int OFF_W  = $clog2(PARALLEL_SIZE + 1);
  localparam int LANE_W = (PARALLEL_SIZE > 1) ? $clog2(PARALLEL_SIZE) : 1;

  // Highest occupancy that still leaves room for a full beat plus a terminator.
  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - PARALLEL_SIZE - 1);

  // Storage and state
  hit_entry_t        mem_q [DEPTH];
  hit_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ready_q, ready_d;
  hit_entry_t        head_q, head_d;
  logic [15:0]       acc_q, acc_d;
  logic [15:0]       frame_hits_q, frame_hits_d;
  logic              frame_done_q, frame_done_d;

  // Compaction results
  logic [PARALLEL_SIZE-1:0][OFF_W-1:0] lane_off;
  logic [OFF_W-1:0]                    hit_cnt;
  logic [LANE_W-1:0]                   hi_lane;

  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  n_push;
  logic [PTR_W-1:0]  slot;
  logic [16:0]       acc_sum;

  stage3_hit_compactor #(
    .PARALLEL_SIZE (PARALLEL_SIZE),
    .OFF_W         (OFF_W),
    .LANE_W        (LANE_W)
  ) u_compactor (
    .in_flag  (in_flag),
    .lane_off (lane_off),
    .hit_cnt  (hit_cnt),
    .hi_lane  (hi_lane)
  );

  always_comb begin
    accept       = in_valid & ready_q;
    pop          = (count_q != '0) & out_ready;
    mem_d        = mem_q;
    n_push       = '0;
    slot         = '0;
    acc_sum      = {1'b0, acc_q} + 17'(hit_cnt);
    acc_d        = acc_q;
    frame_hits_d = frame_hits_q;
    frame_done_d = 1'b0;

    if (accept) begin
      for (int i = 0; i < PARALLEL_SIZE; i++) begin
        if (in_flag[i]) begin
          slot              = wr_ptr_q + PTR_W'(lane_off[i]);
          mem_d[slot].idx    = in_idx[i];
          mem_d[slot].last   = in_last && (LANE_W'(i) == hi_lane);
          mem_d[slot].null_f = 1'b0;
        end
      end

      if (hit_cnt != '0) begin
        n_push = CNT_W'(hit_cnt);
      end else if (in_last) begin
        // A hitless closing beat still has to mark the frame end. If earlier
        // beats had hits, their final entry went out untagged, so the
        // terminator is a plain last marker; otherwise it flags an empty frame.
        mem_d[wr_ptr_q] = '{idx: '0, last: 1'b1, null_f: (acc_q == '0)};
        n_push          = CNT_W'(1);
      end

      if (in_last) begin
        frame_hits_d = sat16(acc_sum);
        frame_done_d = 1'b1;
        acc_d        = '0;
      end else begin
        acc_d = sat16(acc_sum);
      end
    end

    count_d  = count_q + n_push - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    ready_d  = (count_d <= READY_MAX);

    // The head register looks ahead through this cycle's writes, so an entry
    // pushed into an empty FIFO is presented on the very next cycle. When the
    // FIFO goes empty the head keeps its previous contents.
    head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  // NOTE: the entry array has no reset; its contents are meaningless until
  // written, and count_q alone decides which slots are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ready_q      <= 1'b0;
      head_q       <= '0;
      acc_q        <= '0;
      frame_hits_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ready_q      <= ready_d;
      head_q       <= head_d;
      acc_q        <= acc_d;
      frame_hits_q <= frame_hits_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = (count_q != '0);
  assign out_idx    = head_q.idx;
  assign out_last   = head_q.last;
  assign out_null   = head_q.null_f;
  assign frame_hits = frame_hits_q;
  assign frame_done = frame_done_q;

endmodule : stage3_hit_collector

// File: tb/tb_stage3_hit_collector.sv
// -----------------------------------------------------------------------------
// tb_stage3_hit_collector
// Directed and randomized stimulus for stage3_hit_collector, checked every
// cycle against a queue-based reference model of the FIFO and frame counter.
// -----------------------------------------------------------------------------
module tb_stage3_hit_collector;

  localparam int P     = 12;
  localparam int W     = 16;
  localparam int DEPTH = 32;

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic                in_ready;
  logic [P-1:0]        in_flag;
  logic [P-1:0][W-1:0] in_idx;
  logic                in_last;
  logic                out_valid;
  logic                out_ready;
  logic [W-1:0]        out_idx;
  logic                out_last;
  logic                out_null;
  logic [15:0]         frame_hits;
  logic                frame_done;

  stage3_hit_collector #(
    .PARALLEL_SIZE (P),
    .PARA          (W),
    .DEPTH         (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_flag    (in_flag),
    .in_idx     (in_idx),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .out_null   (out_null),
    .frame_hits (frame_hits),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a queue of pending entries plus frame bookkeeping.
  typedef struct {
    logic [W-1:0] idx;
    logic         last;
    logic         nul;
  } ent_t;

  ent_t        q[$];
  ent_t        last_head;
  logic        exp_ready;
  logic        exp_done;
  logic [15:0] exp_hits;
  int          m_acc;

  int n_checks;
  int n_err;
  int dut_acc;
  int dut_pops;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_head = '{idx: '0, last: 1'b0, nul: 1'b0};
    exp_ready = 1'b0;
    exp_done  = 1'b0;
    exp_hits  = '0;
    m_acc     = 0;
  endtask

  task automatic check_outputs(input string tag);
    ent_t h;
    h = (q.size() != 0) ? q[0] : last_head;
    check({tag, " in_ready"},   32'(in_ready),   32'(exp_ready));
    check({tag, " out_valid"},  32'(out_valid),  32'(q.size() != 0));
    check({tag, " out_idx"},    32'(out_idx),    32'(h.idx));
    if (q.size() != 0) begin
      check({tag, " out_last"}, 32'(out_last),   32'(h.last));
      check({tag, " out_null"}, 32'(out_null),   32'(h.nul));
    end
    check({tag, " frame_hits"}, 32'(frame_hits), 32'(exp_hits));
    check({tag, " frame_done"}, 32'(frame_done), 32'(exp_done));
  endtask

  // One clock: decide handshakes from pre-edge state, advance model, compare.
  task automatic step(input string tag);
    bit   acc_now, pop_now;
    int   k;
    ent_t e;
    acc_now = in_valid && exp_ready;
    pop_now = (q.size() != 0) && out_ready;
    if (in_valid && in_ready) dut_acc++;
    if (out_valid && out_ready) dut_pops++;
    @(posedge clk);
    #1;
    exp_done = 1'b0;
    if (pop_now) void'(q.pop_front());
    if (acc_now) begin
      k = 0;
      for (int i = 0; i < P; i++) begin
        if (in_flag[i]) begin
          e = '{idx: in_idx[i], last: 1'b0, nul: 1'b0};
          q.push_back(e);
          k++;
        end
      end
      if (in_last) begin
        if (k > 0) q[q.size()-1].last = 1'b1;
        else begin
          e = '{idx: '0, last: 1'b1, nul: (m_acc == 0)};
          q.push_back(e);
        end
        exp_hits = 16'((m_acc + k > 65535) ? 65535 : m_acc + k);
        exp_done = 1'b1;
        m_acc    = 0;
      end else begin
        m_acc = (m_acc + k > 65535) ? 65535 : m_acc + k;
      end
    end
    exp_ready = (q.size() <= DEPTH - P - 1);
    if (q.size() != 0) last_head = q[0];
    check_outputs(tag);
  endtask

  task automatic drive(input logic v, input logic [P-1:0] f, input logic l, input bit seq_idx);
    in_valid = v;
    in_flag  = f;
    in_last  = l;
    for (int i = 0; i < P; i++) in_idx[i] = seq_idx ? W'(i) : W'($urandom);
  endtask

  task automatic drain(input string tag, input int bound);
    drive(1'b0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < bound && q.size() != 0; i++) step(tag);
    step(tag);
    check({tag, " drained"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    dut_acc  = 0;
    dut_pops = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b1);
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step("release");

    // Single-beat frame: lanes 0,2,5 flagged
    out_ready = 1'b1;
    drive(1'b1, 12'b0000_0010_0101, 1'b1, 1'b1);
    step("t1 accept");
    drive(1'b0, '0, 1'b0, 1'b1);
    check("t1 first idx", 32'(out_idx), 32'(0));
    check("t1 hits", 32'(frame_hits), 32'(3));
    check("t1 done", 32'(frame_done), 32'(1));
    step("t1 out1");
    check("t1 second idx", 32'(out_idx), 32'(2));
    step("t1 out2");
    check("t1 third idx", 32'(out_idx), 32'(5));
    check("t1 third last", 32'(out_last), 32'(1));
    step("t1 empty");

    // Empty frame: null terminator
    drive(1'b1, '0, 1'b1, 1'b0);
    step("t2 accept");
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t2 null", 32'(out_null), 32'(1));
    check("t2 last", 32'(out_last), 32'(1));
    check("t2 idx", 32'(out_idx), 32'(0));
    check("t2 hits", 32'(frame_hits), 32'(0));
    step("t2 empty");

    // Two-beat frame, hitless closing beat
    drive(1'b1, 12'h008, 1'b0, 1'b0);
    in_idx[3] = 16'd7;
    step("t3 beat1");
    check("t3 idx7", 32'(out_idx), 32'(7));
    check("t3 idx7 last", 32'(out_last), 32'(0));
    drive(1'b1, '0, 1'b1, 1'b0);
    step("t3 beat2");
    drive(1'b0, '0, 1'b0, 1'b0);
    check("t3 term idx", 32'(out_idx), 32'(0));
    check("t3 term last", 32'(out_last), 32'(1));
    check("t3 term null", 32'(out_null), 32'(0));
    check("t3 hits", 32'(frame_hits), 32'(1));
    step("t3 empty");

    // Backpressure: only two full beats fit before in_ready drops
    out_ready = 1'b0;
    dut_acc   = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, '1, 1'b0, 1'b0);
      step("bp fill");
    end
    check("bp accepts", 32'(dut_acc), 32'(2));
    check("bp ready low", 32'(in_ready), 32'(0));
    drain("bp drain", 40);

    // Simultaneous push and pop at count 19
    out_ready = 1'b0;
    drive(1'b1, '1, 1'b0, 1'b0);
    step("pp fill12");
    drive(1'b1, 12'h07F, 1'b0, 1'b0);
    step("pp fill19");
    check("pp ready at 19", 32'(in_ready), 32'(1));
    dut_pops  = 0;
    out_ready = 1'b1;
    drive(1'b1, '1, 1'b1, 1'b0);
    step("pp push+pop");
    check("pp ready at 30", 32'(in_ready), 32'(0));
    drain("pp drain", 40);
    check("pp total pops", 32'(dut_pops), 32'(31));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), P'($urandom & $urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end
    drain("rand drain", 60);

    // Reset during a drain with 10 entries pending
    out_ready = 1'b0;
    drive(1'b1, 12'h3FF, 1'b0, 1'b0);
    step("rst fill");
    drive(1'b0, '0, 1'b0, 1'b0);
    out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst async");
    check("rst out_idx zero", 32'(out_idx), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step("rst release");
    check("rst no valid", 32'(out_valid), 32'(0));
    drive(1'b1, 12'h001, 1'b1, 1'b0);
    step("rst new frame");
    drive(1'b0, '0, 1'b0, 1'b0);
    check("rst new hits", 32'(frame_hits), 32'(1));
    drain("rst drain", 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_stage3_hit_collector
